// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the I/D memory port arbiter: FSM state codes and grant encodings.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'b00,
    ARB_BUSY_I = 2'b01,
    ARB_BUSY_D = 2'b10
  } arb_state_e;

  localparam logic [1:0] GRANT_NONE = 2'b00;
  localparam logic [1:0] GRANT_I    = 2'b01;
  localparam logic [1:0] GRANT_D    = 2'b10;

  // last_grant encoding; also the rr_pick2 pick encoding (a = I, b = D)
  localparam logic LAST_I = 1'b0;
  localparam logic LAST_D = 1'b1;

  function automatic logic [1:0] grant_of(arb_state_e s);
    case (s)
      ARB_BUSY_I: grant_of = GRANT_I;
      ARB_BUSY_D: grant_of = GRANT_D;
      default:    grant_of = GRANT_NONE;
    endcase
  endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_pick2.sv
// Combinational 2-way round-robin pick: on a tie the side that did not win last time is chosen.
module rr_pick2 (
  input  logic req_a,
  input  logic req_b,
  input  logic last,   // 0: a won last, 1: b won last
  output logic pick,   // 0: a, 1: b
  output logic valid
);

  assign valid = req_a | req_b;
  assign pick  = (req_a & req_b) ? ~last : req_b;

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates instruction-fetch (I) and data (D) requesters onto one single-port memory.
// Optional ARB_TIMEOUT_EN adds a mem_ack watchdog that aborts the transaction with arb_err.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ack,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [1:0]        grant,
  output logic              arb_err
);

  arb_state_e        state_q, state_d;
  logic              last_q;
  logic              cmd_we_q;
  logic [ADDR_W-1:0] cmd_addr_q;
  logic [DATA_W-1:0] cmd_wdata_q;
  logic [DATA_W-1:0] i_hold_q, d_hold_q;
  logic [DATA_W-1:0] rsp_data;
  logic              pick, pick_vld;
  logic              load, expire, err, i_done, d_done;

  rr_pick2 u_pick (
    .req_a (i_req),
    .req_b (d_req),
    .last  (last_q),
    .pick  (pick),
    .valid (pick_vld)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) state_q <= ARB_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    i_done  = 1'b0;
    d_done  = 1'b0;
    err     = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        if (pick_vld) begin
          load    = 1'b1;
          state_d = (pick == LAST_D) ? ARB_BUSY_D : ARB_BUSY_I;
        end
      end
      ARB_BUSY_I: begin
        if (mem_ack || expire) begin
          i_done  = 1'b1;
          err     = !mem_ack;
          state_d = ARB_IDLE;
        end
      end
      ARB_BUSY_D: begin
        if (mem_ack || expire) begin
          d_done  = 1'b1;
          err     = !mem_ack;
          state_d = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  // A transaction cut short by reset never acknowledges, even if mem_ack coincides.
  assign i_ack    = i_done & reset_n;
  assign d_ack    = d_done & reset_n;
  assign arb_err  = err & reset_n;
  assign rsp_data = err ? {DATA_W{1'b1}} : mem_rdata;
  assign i_rdata  = i_ack ? rsp_data : i_hold_q;
  assign d_rdata  = d_ack ? rsp_data : d_hold_q;

  assign mem_req   = (state_q != ARB_IDLE);
  assign mem_we    = mem_req & cmd_we_q;
  assign mem_addr  = mem_req ? cmd_addr_q  : '0;
  assign mem_wdata = mem_req ? cmd_wdata_q : '0;
  assign grant     = grant_of(state_q);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      last_q      <= LAST_I;
      cmd_we_q    <= 1'b0;
      cmd_addr_q  <= '0;
      cmd_wdata_q <= '0;
      i_hold_q    <= '0;
      d_hold_q    <= '0;
    end else begin
      if (load) begin
        last_q      <= pick;
        cmd_we_q    <= (pick == LAST_D) & d_we;
        cmd_addr_q  <= (pick == LAST_D) ? d_addr  : i_addr;
        cmd_wdata_q <= (pick == LAST_D) ? d_wdata : '0;
      end
      if (i_ack) i_hold_q <= rsp_data;
      if (d_ack) d_hold_q <= rsp_data;
    end
  end

`ifdef ARB_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT > 255) ? $clog2(TIMEOUT + 1) : 8;
  logic [CNT_W-1:0] wait_cnt_q;

  // Counter reads 0 in the first BUSY cycle, so expiry lands in BUSY cycle number TIMEOUT.
  always_ff @(posedge clk) begin
    if (!reset_n)             wait_cnt_q <= '0;
    else if (load)            wait_cnt_q <= '0;
    else if (mem_req)         wait_cnt_q <= wait_cnt_q + 1'b1;
  end

  assign expire = mem_req && (wait_cnt_q == CNT_W'(TIMEOUT - 1));
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT == 0);
  assign expire         = 1'b0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: transaction-level model plus directed scenarios.
module tb_mem_port_arbiter;

  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        i_req, d_req, d_we, mem_ack;
  logic [15:0] i_addr, d_addr, d_wdata, mem_rdata;
  logic        i_ack, d_ack, mem_req, mem_we, arb_err;
  logic [15:0] i_rdata, d_rdata, mem_addr, mem_wdata;
  logic [1:0]  grant;

  int checks = 0;
  int failures = 0;

  mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset_n(reset_n),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .grant(grant), .arb_err(arb_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Model: who owns the memory (0 none, 1 I, 2 D), who won last, and the latched command.
  int          m_side = 0;
  int          m_last = 1;
  logic        m_we = 1'b0;
  logic [15:0] m_addr = '0, m_wdata = '0, m_ihold = '0;
  bit          model_ok = 1'b0;
`ifdef ARB_TIMEOUT_EN
  int          m_bcyc = 0;
`endif

  logic        exp_done, exp_i_ack, exp_d_ack, exp_err, m_expire;
  logic [15:0] exp_rsp;

  always_comb begin
    m_expire = 1'b0;
`ifdef ARB_TIMEOUT_EN
    m_expire = (m_bcyc == TMO);
`endif
    exp_done  = (m_side != 0) && (mem_ack || m_expire);
    exp_i_ack = exp_done && (m_side == 1) && reset_n;
    exp_d_ack = exp_done && (m_side == 2) && reset_n;
    exp_err   = exp_done && !mem_ack && reset_n;
    exp_rsp   = mem_ack ? mem_rdata : 16'hFFFF;
  end

  always @(posedge clk) begin
    if (!reset_n) begin
      m_side   = 0;
      m_last   = 1;
      m_ihold  = '0;
      model_ok = 1'b1;
    end else if (m_side != 0) begin
      if (exp_i_ack) m_ihold = exp_rsp;
      if (exp_done) m_side = 0;
`ifdef ARB_TIMEOUT_EN
      else m_bcyc++;
`endif
    end else if (i_req || d_req) begin
      m_side  = (i_req && d_req) ? ((m_last == 1) ? 2 : 1) : (d_req ? 2 : 1);
      m_last  = m_side;
      m_we    = (m_side == 2) && d_we;
      m_addr  = (m_side == 2) ? d_addr : i_addr;
      m_wdata = d_wdata;
`ifdef ARB_TIMEOUT_EN
      m_bcyc  = 1;
`endif
    end
  end

  always @(negedge clk) begin
    if (model_ok) begin
      chk("mem_req", mem_req, m_side != 0);
      chk("grant", grant, m_side);
      chk("i_ack", i_ack, exp_i_ack);
      chk("d_ack", d_ack, exp_d_ack);
      chk("arb_err", arb_err, exp_err);
      chk("i_rdata", i_rdata, exp_i_ack ? exp_rsp : m_ihold);
      if (m_side != 0) begin
        chk("mem_we", mem_we, m_we);
        chk("mem_addr", mem_addr, m_addr);
        if (m_we) chk("mem_wdata", mem_wdata, m_wdata);
      end
      if (exp_d_ack && !m_we) chk("d_rdata", d_rdata, exp_rsp);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n = 1'b0; i_req = 0; d_req = 0; d_we = 0; mem_ack = 0;
    i_addr = '0; d_addr = '0; d_wdata = '0; mem_rdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_mem_req", mem_req, 0);   chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0); chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_grant", grant, 0);       chk("rst_acks", {i_ack, d_ack, arb_err}, 0);
    chk("rst_rdata", {i_rdata, d_rdata}, 0);
    cyc(); reset_n = 1'b1;

    // I only, mem_ack three cycles after the request
    i_req = 1; i_addr = 16'h0010;
    cyc();
    @(negedge clk); chk("s1_grant", grant, 2'b01); chk("s1_addr", mem_addr, 16'h0010);
    chk("s1_we", mem_we, 0);
    cyc();
    cyc(); mem_ack = 1; mem_rdata = 16'hBEEF;
    @(negedge clk); chk("s1_iack", i_ack, 1); chk("s1_irdata", i_rdata, 16'hBEEF);
    chk("s1_dack", d_ack, 0);
    cyc(); mem_ack = 0; i_req = 0;
    @(negedge clk); chk("s1_hold", i_rdata, 16'hBEEF);

    // Tie: D wins first, d_addr changes mid-flight, then I, then next tie goes to D
    i_req = 1; i_addr = 16'h0040;
    d_req = 1; d_we = 1; d_addr = 16'h0200; d_wdata = 16'h1234;
    cyc();
    @(negedge clk); chk("s2_grant", grant, 2'b10); chk("s2_we", mem_we, 1);
    chk("s2_wdata", mem_wdata, 16'h1234); chk("s2_addr", mem_addr, 16'h0200);
    cyc(); d_addr = 16'h0333;
    @(negedge clk); chk("s2_addr_latched", mem_addr, 16'h0200);
    cyc(); mem_ack = 1; mem_rdata = 16'h0000;
    @(negedge clk); chk("s2_dack", d_ack, 1); chk("s2_iack", i_ack, 0);
    cyc(); mem_ack = 0; d_req = 0; d_we = 0;
    @(negedge clk); chk("s2_idle_gap", grant, 2'b00);
    cyc();
    @(negedge clk); chk("s2_grant_i", grant, 2'b01); chk("s2_addr_i", mem_addr, 16'h0040);
    cyc(); mem_ack = 1; mem_rdata = 16'h5555;
    @(negedge clk); chk("s2_iack2", i_ack, 1);
    cyc(); mem_ack = 0; d_req = 1; d_addr = 16'h0300;
    cyc();
    @(negedge clk); chk("s2_tie2_grant", grant, 2'b10); chk("s2_tie2_addr", mem_addr, 16'h0300);
    cyc(); mem_ack = 1; mem_rdata = 16'h0A0A;
    @(negedge clk); chk("s2_dread", d_rdata, 16'h0A0A);
    cyc(); mem_ack = 0; d_req = 0;
    cyc(); mem_ack = 1; mem_rdata = 16'h1111;
    @(negedge clk); chk("s2_grant_i2", grant, 2'b01); chk("s2_irdata2", i_rdata, 16'h1111);
    cyc(); mem_ack = 0; i_req = 0;

    // Stray mem_ack while idle
    mem_ack = 1; mem_rdata = 16'hDEAD;
    @(negedge clk); chk("idle_acks", {i_ack, d_ack}, 0); chk("idle_hold", i_rdata, 16'h1111);
    cyc(); mem_ack = 0;
    @(negedge clk); chk("idle_mem_req", mem_req, 0);

    // Requester drops req early; ack still delivered
    d_req = 1; d_we = 0; d_addr = 16'h0500;
    cyc(); d_req = 0;
    cyc(); mem_ack = 1; mem_rdata = 16'h7777;
    @(negedge clk); chk("drop_dack", d_ack, 1); chk("drop_drdata", d_rdata, 16'h7777);
    cyc(); mem_ack = 0;

    // Reset while BUSY_D: no ack afterwards, last_grant back to I
    d_req = 1; d_we = 1; d_addr = 16'h0600; d_wdata = 16'hABCD;
    cyc();
    @(negedge clk); chk("rstb_grant", grant, 2'b10);
    cyc(); reset_n = 0;
    cyc(); reset_n = 1; d_req = 0; mem_ack = 1; mem_rdata = 16'h2222;
    @(negedge clk); chk("rstb_mem_req", mem_req, 0); chk("rstb_dack", d_ack, 0);
    cyc(); mem_ack = 0; i_req = 1; i_addr = 16'h0080; d_req = 1; d_we = 0; d_addr = 16'h0700;
    cyc();
    @(negedge clk); chk("rstb_tie_d", grant, 2'b10);
    cyc(); mem_ack = 1; mem_rdata = 16'h3333;
    cyc(); mem_ack = 0; d_req = 0;
    cyc(); mem_ack = 1; mem_rdata = 16'h4444;
    @(negedge clk); chk("rstb_iack", i_ack, 1);
    cyc(); mem_ack = 0; i_req = 0;
    cyc();

`ifdef ARB_TIMEOUT_EN
    // Watchdog: no mem_ack, abort in the TMO-th busy cycle
    i_req = 1; i_addr = 16'h0090;
    cyc();
    repeat (TMO - 1) cyc();
    @(negedge clk); chk("tmo_err", arb_err, 1); chk("tmo_iack", i_ack, 1);
    chk("tmo_rdata", i_rdata, 16'hFFFF);
    cyc(); i_req = 0;
    @(negedge clk); chk("tmo_idle", mem_req, 0);
    cyc();
`endif

    repeat (2) cyc();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
